// File: rtl/cmp_seq.sv
// cmp_seq: multi-cycle WIDTH-bit magnitude comparator with runtime signed/unsigned mode.
// Operands are compared CHUNK bits per cycle starting from the most significant
// chunk, stopping as soon as the order is known.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request a compare (accepted in IDLE or DONE only)
//   signed_mode  1 = two's-complement compare, 0 = unsigned (latched with start)
//   a, b         WIDTH-bit operands (latched with start)
//   busy         high while comparing
//   done         one-cycle pulse, new result on gt/eq/lt
//   gt, eq, lt   result flags, held until the next result is written
module cmp_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDXW-1:0]  idx;
   logic [IDXW-1:0]  idx_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sm_q;
   logic [CHUNK-1:0] slice_a;
   logic [CHUNK-1:0] slice_b;
   logic             sign_split;
   logic             load;
   logic             decide;
   logic             res_gt;
   logic             res_eq;
   logic             res_lt;

   // The chunk under inspection this cycle, taken from the latched operands.
   assign slice_a = a_q[int'(idx)*CHUNK +: CHUNK];
   assign slice_b = b_q[int'(idx)*CHUNK +: CHUNK];

   // Only on the top chunk in signed mode do differing sign bits settle the
   // result outright; with equal signs the unsigned chunk order is already right.
   assign sign_split = sm_q && (idx == IDX_TOP) && (a_q[WIDTH-1] != b_q[WIDTH-1]);

   assign busy = (state == CMP);
   assign done = (state == DONE);

   // Next-state logic: accept start from IDLE/DONE, walk the chunks in CMP and
   // produce a one-hot decision when the order is known.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      load      = 1'b0;
      decide    = 1'b0;
      res_gt    = 1'b0;
      res_eq    = 1'b0;
      res_lt    = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               load      = 1'b1;
               idx_nxt   = IDX_TOP;
               state_nxt = CMP;
            end else begin
               state_nxt = IDLE;
            end
         end
         CMP: begin
            if (sign_split) begin
               decide    = 1'b1;
               res_lt    = a_q[WIDTH-1];
               res_gt    = ~a_q[WIDTH-1];
               state_nxt = DONE;
            end else if (slice_a > slice_b) begin
               decide    = 1'b1;
               res_gt    = 1'b1;
               state_nxt = DONE;
            end else if (slice_a < slice_b) begin
               decide    = 1'b1;
               res_lt    = 1'b1;
               state_nxt = DONE;
            end else if (idx == '0) begin
               decide    = 1'b1;
               res_eq    = 1'b1;
               state_nxt = DONE;
            end else begin
               idx_nxt = idx - IDXW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, chunk index and result flags. Flags change only on a decision so
   // they stay visible through IDLE and any following compare.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         gt    <= 1'b0;
         eq    <= 1'b0;
         lt    <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (decide) begin
            gt <= res_gt;
            eq <= res_eq;
            lt <= res_lt;
         end
      end
   end

   // Operand capture; the inputs are free to change once a compare is accepted.
   always_ff @(posedge clk) begin
      if (load) begin
         a_q  <= a;
         b_q  <= b;
         sm_q <= signed_mode;
      end
   end

endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: directed self-checking bench for cmp_seq. Three instances with
// CHUNK = 1, 4 and 16 share the same stimulus; the directed handshake checks
// look at the CHUNK=4 instance and the final sweep checks all three.
module tb_cmp_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic        signed_mode;
   logic [15:0] a;
   logic [15:0] b;
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [2:0]  gt_v;
   logic [2:0]  eq_v;
   logic [2:0]  lt_v;

   int compared;
   int mismatched;
   int lat;
   int busy_cnt;
   int sw_lat[3];
   logic [2:0] sw_flags[3];
   int chunks[3];

   typedef struct {
      logic        sm;
      logic [15:0] av;
      logic [15:0] bv;
      logic [2:0]  fl;
   } vec_t;

   vec_t vecs[6];

   cmp_seq #(.WIDTH(16), .CHUNK(1)) dut_c1 (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy_v[0]), .done(done_v[0]),
      .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0])
   );

   cmp_seq #(.WIDTH(16), .CHUNK(4)) dut_c4 (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy_v[1]), .done(done_v[1]),
      .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1])
   );

   cmp_seq #(.WIDTH(16), .CHUNK(16)) dut_c16 (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy_v[2]), .done(done_v[2]),
      .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2])
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      if (obs !== expv) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // Present one start request, hold it for one edge (T0), return #1 after T0.
   task automatic applyStimulus(input logic sm, input logic [15:0] av, input logic [15:0] bv);
      @(negedge clk);
      start       = 1'b1;
      signed_mode = sm;
      a           = av;
      b           = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges until the CHUNK=4 instance pulses done; lat0 is the edge count
   // already elapsed (T0 counts as 1). Also counts cycles observed with busy high.
   task automatic waitDone(input int lat0, output int lat_o, output int busy_o);
      lat_o  = lat0;
      busy_o = busy_v[1] ? 1 : 0;
      while (!done_v[1] && lat_o < 40) begin
         @(posedge clk);
         #1;
         lat_o++;
         if (busy_v[1]) busy_o++;
      end
   endtask

   // Reference latency: signs differing in signed mode settles on the first
   // chunk, otherwise the first differing chunk from the top does.
   function automatic int expLat(input logic sm, input logic [15:0] av, input logic [15:0] bv, input int ch);
      int n;
      int m;
      n = 16 / ch;
      m = (1 << ch) - 1;
      if (sm && (av[15] != bv[15])) return 2;
      for (int i = n - 1; i >= 0; i--) begin
         if (((int'(av) >> (i * ch)) & m) != ((int'(bv) >> (i * ch)) & m)) return (n - i) + 1;
      end
      return n + 1;
   endfunction

   // Run one start on all three instances and record each one's latency and flags.
   task automatic sweepWait();
      int n;
      for (int j = 0; j < 3; j++) begin
         sw_lat[j]   = 0;
         sw_flags[j] = 3'b000;
      end
      n = 1;
      while ((sw_lat[0] == 0 || sw_lat[1] == 0 || sw_lat[2] == 0) && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         for (int j = 0; j < 3; j++) begin
            if (sw_lat[j] == 0 && done_v[j]) begin
               sw_lat[j]   = n;
               sw_flags[j] = {gt_v[j], eq_v[j], lt_v[j]};
            end
         end
      end
   endtask

   // Main directed sequence followed by the three-way parameter sweep.
   initial begin
      logic done_seen;
      compared    = 0;
      mismatched  = 0;
      rst         = 1'b1;
      start       = 1'b0;
      signed_mode = 1'b0;
      a           = '0;
      b           = '0;
      chunks      = '{1, 4, 16};
      vecs[0]     = '{1'b0, 16'h8000, 16'h7FFF, 3'b100};
      vecs[1]     = '{1'b1, 16'h8000, 16'h7FFF, 3'b001};
      vecs[2]     = '{1'b1, 16'hFFFE, 16'hFFFF, 3'b001};
      vecs[3]     = '{1'b0, 16'h00F0, 16'h00F0, 3'b010};
      vecs[4]     = '{1'b1, 16'h7FFF, 16'h7FFE, 3'b100};
      vecs[5]     = '{1'b0, 16'h0100, 16'h00FF, 3'b100};

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", 32'(busy_v[1]), 32'd0);
      checkOutput("reset_done", 32'(done_v[1]), 32'd0);
      checkOutput("reset_flags", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Equal operands walk every chunk: busy for 4 cycles, done on the 5th edge.
      applyStimulus(1'b0, 16'h1234, 16'h1234);
      waitDone(1, lat, busy_cnt);
      checkOutput("eq_latency", 32'(lat), 32'd5);
      checkOutput("eq_busy_cycles", 32'(busy_cnt), 32'd4);
      checkOutput("eq_flags", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'b010);
      @(posedge clk);
      #1;
      checkOutput("eq_done_pulse", 32'(done_v[1]), 32'd0);
      checkOutput("eq_flags_held", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'b010);

      // -1 vs 1: signed decides on sign, unsigned on the top chunk.
      applyStimulus(1'b1, 16'hFFFF, 16'h0001);
      waitDone(1, lat, busy_cnt);
      checkOutput("signed_neg_latency", 32'(lat), 32'd2);
      checkOutput("signed_neg_flags", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'b001);
      applyStimulus(1'b0, 16'hFFFF, 16'h0001);
      waitDone(1, lat, busy_cnt);
      checkOutput("unsigned_big_latency", 32'(lat), 32'd2);
      checkOutput("unsigned_big_flags", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'b100);

      // Difference only in the LSB chunk, then a negative-vs-positive signed case.
      applyStimulus(1'b0, 16'h1234, 16'h1235);
      waitDone(1, lat, busy_cnt);
      checkOutput("lsb_diff_latency", 32'(lat), 32'd5);
      checkOutput("lsb_diff_flags", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'b001);
      applyStimulus(1'b1, 16'h9234, 16'h1234);
      waitDone(1, lat, busy_cnt);
      checkOutput("signed_msb_latency", 32'(lat), 32'd2);
      checkOutput("signed_msb_flags", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'b001);

      // A start pulse during CMP with new operands must not disturb the compare.
      applyStimulus(1'b0, 16'h1234, 16'h1234);
      @(negedge clk);
      start       = 1'b1;
      signed_mode = 1'b1;
      a           = 16'hFFFF;
      b           = 16'h0000;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("midstart_busy", 32'(busy_v[1]), 32'd1);
      waitDone(2, lat, busy_cnt);
      checkOutput("midstart_latency", 32'(lat), 32'd5);
      checkOutput("midstart_flags", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'b010);

      // Start during the DONE cycle launches the next compare without an IDLE gap.
      start       = 1'b1;
      signed_mode = 1'b0;
      a           = 16'h0001;
      b           = 16'h0002;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2b_busy", 32'(busy_v[1]), 32'd1);
      checkOutput("b2b_done_low", 32'(done_v[1]), 32'd0);
      waitDone(1, lat, busy_cnt);
      checkOutput("b2b_latency", 32'(lat), 32'd5);
      checkOutput("b2b_flags", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'b001);

      // Reset on the second CMP cycle clears everything and yields no done.
      applyStimulus(1'b1, 16'h0F00, 16'h0F00);
      @(posedge clk);
      #1;
      checkOutput("abort_busy_before", 32'(busy_v[1]), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("abort_outputs", 32'({busy_v[1], done_v[1], gt_v[1], eq_v[1], lt_v[1]}), 32'd0);
      done_seen = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done_v[1] || busy_v[1]) done_seen = 1'b1;
      end
      checkOutput("abort_stays_idle", 32'(done_seen), 32'd0);
      applyStimulus(1'b1, 16'h8000, 16'h7FFF);
      waitDone(1, lat, busy_cnt);
      checkOutput("post_abort_latency", 32'(lat), 32'd2);
      checkOutput("post_abort_flags", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'b001);

      // Realign all three instances, then sweep the vector table across CHUNK sizes.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].sm, vecs[i].av, vecs[i].bv);
         sweepWait();
         for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("sweep%0d_c%0d_flags", i, chunks[j]), 32'(sw_flags[j]), 32'(vecs[i].fl));
            checkOutput($sformatf("sweep%0d_c%0d_latency", i, chunks[j]), 32'(sw_lat[j]),
                        32'(expLat(vecs[i].sm, vecs[i].av, vecs[i].bv, chunks[j])));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
